// File: rtl/enemy_spawner_pkg.sv
// Shared game definitions for the enemy spawner: FSM states, queue entry
// layout, the end-of-queue sentinel and the default number of enemy slots.
package enemy_spawner_pkg;

  localparam int NSLOT = 8;

  localparam logic [11:0] TS_SENTINEL = 12'hFFF;
  localparam logic [11:0] TIME_MAX    = 12'hFFE;

  // Queue ROM entry layout: {timestamp[14:3], type[2:0]}
  localparam int ENTRY_TS_MSB   = 14;
  localparam int ENTRY_TS_LSB   = 3;
  localparam int ENTRY_TYPE_MSB = 2;
  localparam int ENTRY_TYPE_LSB = 0;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    WAIT,
    HOLD,
    ALLOC,
    OFFER,
    DONE
  } state_e;

endpackage

// File: rtl/enemy_spawner_free_slot_finder.sv
// Lowest-index priority encoder over a mask of free enemy slots.
module free_slot_finder
  import enemy_spawner_pkg::*;
#(
  parameter int N  = NSLOT,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  mask_i,
  output logic [IW-1:0] idx_o,
  output logic          found_o
);

  // Scanning downwards lets the lowest set bit be the last one written.
  always_comb begin
    idx_o   = '0;
    found_o = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      if (mask_i[i]) begin
        idx_o   = IW'(i);
        found_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/enemy_spawner.sv
// Walks a level's spawn queue ROM, waits for each entry's timestamp in game
// frames, reserves the lowest free enemy slot and offers it to the engine.
module enemy_spawner #(
  parameter int QDEPTH = 128,
  parameter int NSLOT  = enemy_spawner_pkg::NSLOT
) (
  input  logic             clk_25MHz,
  input  logic             rst,
  input  logic             level_start,
  input  logic [1:0]       level_sel,
  input  logic             stop,
  input  logic             pause,
  input  logic             frame_tick,
  output logic [8:0]       q_addr,
  input  logic [14:0]      q_data,
  input  logic [NSLOT-1:0] enemy_exist,
  output logic             spawn_valid,
  input  logic             spawn_ready,
  output logic [2:0]       spawn_slot,
  output logic [2:0]       spawn_type,
  output logic [11:0]      game_time,
  output logic             queue_done
);
  import enemy_spawner_pkg::*;

  localparam int SW = (NSLOT > 1) ? $clog2(NSLOT) : 1;

  state_e           state_q;
  logic [1:0]       level_q;
  logic [6:0]       index_q;
  logic [11:0]      ts_q;
  logic [2:0]       type_q;
  logic [11:0]      game_time_q, game_time_d;
  logic [NSLOT-1:0] reserved_q, reserved_d, reserve_set;
  logic             spawn_valid_q;
  logic [2:0]       spawn_slot_q, spawn_type_q;

  logic [NSLOT-1:0] free_mask;
  logic [SW-1:0]    free_idx;
  logic             free_found;
  logic             start, transfer, due, last_entry;

  assign start      = level_start && (level_sel != 2'd0);
  assign transfer   = spawn_valid_q && spawn_ready;
  assign due        = game_time_q >= ts_q;
  assign last_entry = index_q == 7'(QDEPTH - 1);
  assign free_mask  = ~(enemy_exist | reserved_q);

  free_slot_finder #(.N(NSLOT)) u_free_slot_finder (
    .mask_i  (free_mask),
    .idx_o   (free_idx),
    .found_o (free_found)
  );

  always_comb begin
    game_time_d = game_time_q;
    if (state_q != IDLE && frame_tick && !pause && game_time_q < TIME_MAX)
      game_time_d = game_time_q + 12'd1;
    reserve_set = '0;
    if (state_q == OFFER && transfer)
      reserve_set[spawn_slot_q] = 1'b1;
    reserved_d = (reserved_q & ~enemy_exist) | reserve_set;
  end

  // HOLD allocates directly when a slot is free so equal-timestamp entries
  // stream at one per 4 cycles; ALLOC is only the wait-for-free-slot state.
  always_ff @(posedge clk_25MHz) begin
    if (rst) begin
      state_q       <= IDLE;
      level_q       <= '0;
      index_q       <= '0;
      ts_q          <= '0;
      type_q        <= '0;
      game_time_q   <= '0;
      reserved_q    <= '0;
      spawn_valid_q <= 1'b0;
      spawn_slot_q  <= '0;
      spawn_type_q  <= '0;
    end else if (start) begin
      state_q       <= FETCH;
      level_q       <= level_sel;
      index_q       <= '0;
      game_time_q   <= '0;
      reserved_q    <= '0;
      spawn_valid_q <= 1'b0;
    end else if (stop) begin
      state_q       <= IDLE;
      spawn_valid_q <= 1'b0;
    end else begin
      game_time_q <= game_time_d;
      reserved_q  <= reserved_d;
      case (state_q)
        FETCH: state_q <= WAIT;
        WAIT: begin
          ts_q    <= q_data[ENTRY_TS_MSB:ENTRY_TS_LSB];
          type_q  <= q_data[ENTRY_TYPE_MSB:ENTRY_TYPE_LSB];
          state_q <= HOLD;
        end
        HOLD: begin
          if (ts_q == TS_SENTINEL) begin
            state_q <= DONE;
          end else if (due) begin
            if (free_found) begin
              spawn_slot_q  <= 3'(free_idx);
              spawn_type_q  <= type_q;
              spawn_valid_q <= 1'b1;
              state_q       <= OFFER;
            end else begin
              state_q <= ALLOC;
            end
          end
        end
        ALLOC: begin
          if (free_found) begin
            spawn_slot_q  <= 3'(free_idx);
            spawn_type_q  <= type_q;
            spawn_valid_q <= 1'b1;
            state_q       <= OFFER;
          end
        end
        OFFER: begin
          if (transfer) begin
            spawn_valid_q <= 1'b0;
            if (last_entry) begin
              state_q <= DONE;
            end else begin
              index_q <= index_q + 7'd1;
              state_q <= FETCH;
            end
          end
        end
        IDLE, DONE: state_q <= state_q;
        default:    state_q <= IDLE;
      endcase
    end
  end

  assign q_addr      = {level_q, index_q};
  assign spawn_valid = spawn_valid_q;
  assign spawn_slot  = spawn_slot_q;
  assign spawn_type  = spawn_type_q;
  assign game_time   = game_time_q;
  assign queue_done  = (state_q == DONE);

endmodule

// File: tb/tb_enemy_spawner.sv
// Directed bench for enemy_spawner: a queue ROM model, an engine model and a
// scoreboard that checks every accepted spawn against hand-computed entries.
module tb_enemy_spawner;

  typedef struct packed {
    logic [2:0] slot;
    logic [2:0] kind;
    logic [8:0] addr;
  } xfer_t;

  logic        clk_25MHz = 1'b0;
  logic        rst, level_start, stop, pause, frame_tick, spawn_ready;
  logic [1:0]  level_sel;
  logic [8:0]  q_addr;
  logic [14:0] q_data;
  logic [7:0]  enemy_exist;
  logic        spawn_valid, queue_done;
  logic [2:0]  spawn_slot, spawn_type;
  logic [11:0] game_time;

  logic [14:0] rom [0:511];
  xfer_t       expQ[$];
  int          xferCyc[$];
  int          cyc = 0;
  int          checks = 0;
  int          errors = 0;
  bit          engineEcho = 1'b0;

  enemy_spawner #(.QDEPTH(128), .NSLOT(8)) dut (
    .clk_25MHz   (clk_25MHz),
    .rst         (rst),
    .level_start (level_start),
    .level_sel   (level_sel),
    .stop        (stop),
    .pause       (pause),
    .frame_tick  (frame_tick),
    .q_addr      (q_addr),
    .q_data      (q_data),
    .enemy_exist (enemy_exist),
    .spawn_valid (spawn_valid),
    .spawn_ready (spawn_ready),
    .spawn_slot  (spawn_slot),
    .spawn_type  (spawn_type),
    .game_time   (game_time),
    .queue_done  (queue_done)
  );

  always #20 clk_25MHz = ~clk_25MHz;

  always @(posedge clk_25MHz) cyc <= cyc + 1;

  // Synchronous queue ROM: data appears one cycle after the address.
  always @(posedge clk_25MHz) q_data <= rom[q_addr];

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  task automatic expectXfer(input logic [2:0] slot, input logic [2:0] kind, input logic [8:0] addr);
    xfer_t x;
    x.slot = slot;
    x.kind = kind;
    x.addr = addr;
    expQ.push_back(x);
  endtask

  // Monitor samples late in the low phase, after inputs and outputs settle.
  always begin : monitor
    xfer_t      e;
    logic [2:0] s;
    @(negedge clk_25MHz);
    #10;
    if (rst === 1'b0 && spawn_valid === 1'b1 && spawn_ready === 1'b1) begin
      xferCyc.push_back(cyc);
      s = spawn_slot;
      if (expQ.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL xfer_unexpected: got slot=%0d type=%0d addr=0x%0h, expected no transfer",
                 spawn_slot, spawn_type, q_addr);
      end else begin
        e = expQ.pop_front();
        checkOutput("xfer", 32'({spawn_slot, spawn_type, q_addr}), 32'(e));
      end
      if (engineEcho) begin
        @(negedge clk_25MHz);
        enemy_exist = 8'd1 << s;
        @(negedge clk_25MHz);
        enemy_exist = 8'd0;
      end
    end
  end

  task automatic applyStimulus(input logic [1:0] lvl);
    level_sel   = lvl;
    level_start = 1'b1;
    @(negedge clk_25MHz);
    level_start = 1'b0;
  endtask

  task automatic pulseTick();
    frame_tick = 1'b1;
    @(negedge clk_25MHz);
    frame_tick = 1'b0;
    @(negedge clk_25MHz);
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk_25MHz);
  endtask

  task automatic waitValid(input int budget, input string name);
    int n = 0;
    while (spawn_valid !== 1'b1 && n < budget) begin
      @(negedge clk_25MHz);
      n++;
    end
    checkOutput(name, 32'(spawn_valid), 32'd1);
  endtask

  task automatic waitXfers(input int target, input int budget, input string name);
    int n = 0;
    while (xferCyc.size() < target && n < budget) begin
      @(negedge clk_25MHz);
      n++;
    end
    checkOutput(name, 32'(xferCyc.size()), 32'(target));
  endtask

  initial begin
    int base;
    for (int i = 0; i < 512; i++) rom[i] = {12'hFFF, 3'd0};
    rom[9'h100] = {12'd5, 3'd3};
    rom[9'h101] = {12'hFFF, 3'd0};
    rom[9'h080] = {12'd10, 3'd1};
    rom[9'h081] = {12'd10, 3'd2};
    rom[9'h082] = {12'd10, 3'd4};
    rom[9'h083] = {12'hFFF, 3'd0};
    rom[9'h180] = {12'd2, 3'd6};
    rom[9'h181] = {12'hFFF, 3'd0};

    rst = 1'b1; level_start = 1'b0; level_sel = 2'd0; stop = 1'b0; pause = 1'b0;
    frame_tick = 1'b0; spawn_ready = 1'b0; enemy_exist = 8'd0;
    cycles(3);
    rst = 1'b0;
    @(negedge clk_25MHz);
    checkOutput("rst_spawn_valid", 32'(spawn_valid), 32'd0);
    checkOutput("rst_spawn_slot", 32'(spawn_slot), 32'd0);
    checkOutput("rst_spawn_type", 32'(spawn_type), 32'd0);
    checkOutput("rst_game_time", 32'(game_time), 32'd0);
    checkOutput("rst_queue_done", 32'(queue_done), 32'd0);
    checkOutput("rst_q_addr", 32'(q_addr), 32'd0);

    $display("[TB] level_sel=0 is ignored");
    applyStimulus(2'd0);
    pulseTick();
    checkOutput("sel0_game_time", 32'(game_time), 32'd0);
    checkOutput("sel0_q_addr", 32'(q_addr), 32'd0);

    $display("[TB] level 2: single entry at ts=5 then sentinel");
    spawn_ready = 1'b1;
    base = xferCyc.size();
    expectXfer(3'd0, 3'd3, 9'h100);
    applyStimulus(2'd2);
    repeat (4) pulseTick();
    cycles(3);
    checkOutput("s1_no_early_spawn", 32'(spawn_valid), 32'd0);
    checkOutput("s1_game_time_4", 32'(game_time), 32'd4);
    pulseTick();
    waitValid(4, "s1_valid_rise");
    waitXfers(base + 1, 10, "s1_xfer_count");
    cycles(5);
    checkOutput("s1_queue_done", 32'(queue_done), 32'd1);
    checkOutput("s1_q_addr_end", 32'(q_addr), 32'h101);

    $display("[TB] level 1: three entries with equal timestamps");
    base = xferCyc.size();
    expectXfer(3'd0, 3'd1, 9'h080);
    expectXfer(3'd1, 3'd2, 9'h081);
    expectXfer(3'd2, 3'd4, 9'h082);
    applyStimulus(2'd1);
    checkOutput("s2_restart_game_time", 32'(game_time), 32'd0);
    repeat (10) pulseTick();
    waitXfers(base + 3, 30, "s2_xfer_count");
    if (xferCyc.size() >= base + 3) begin
      checkOutput("s2_spacing_1", 32'(xferCyc[base + 1] - xferCyc[base]), 32'd4);
      checkOutput("s2_spacing_2", 32'(xferCyc[base + 2] - xferCyc[base + 1]), 32'd4);
    end
    cycles(5);
    checkOutput("s2_queue_done", 32'(queue_done), 32'd1);

    $display("[TB] level 3: all slots occupied, then slot 5 frees");
    spawn_ready = 1'b0;
    enemy_exist = 8'hFF;
    applyStimulus(2'd3);
    repeat (2) pulseTick();
    for (int i = 0; i < 6; i++) begin
      @(negedge clk_25MHz);
      checkOutput("s3_blocked_no_valid", 32'(spawn_valid), 32'd0);
    end
    enemy_exist = 8'hDF;
    @(negedge clk_25MHz);
    checkOutput("s3_offer_after_free", 32'({spawn_valid, spawn_slot, spawn_type}),
                32'({1'b1, 3'd5, 3'd6}));

    $display("[TB] offer held without ready, paused ticks");
    pause = 1'b1;
    for (int i = 0; i < 20; i++) begin
      frame_tick = (i % 2 == 0);
      @(negedge clk_25MHz);
      checkOutput("s4_offer_stable", 32'({spawn_valid, spawn_slot, spawn_type, q_addr}),
                  32'({1'b1, 3'd5, 3'd6, 9'h180}));
    end
    frame_tick = 1'b0;
    checkOutput("s4_paused_game_time", 32'(game_time), 32'd2);
    pause = 1'b0;
    pulseTick();
    checkOutput("s4_unpaused_game_time", 32'(game_time), 32'd3);
    pause = 1'b1;
    base = xferCyc.size();
    expectXfer(3'd5, 3'd6, 9'h180);
    spawn_ready = 1'b1;
    waitXfers(base + 1, 5, "s4_xfer_during_pause");
    spawn_ready = 1'b0;
    pause = 1'b0;
    enemy_exist = 8'd0;
    cycles(5);
    checkOutput("s4_queue_done", 32'(queue_done), 32'd1);

    $display("[TB] stop during offer, then restart");
    applyStimulus(2'd2);
    repeat (5) pulseTick();
    waitValid(6, "s5_valid");
    checkOutput("s5_offer_slot_type", 32'({spawn_slot, spawn_type}), 32'({3'd0, 3'd3}));
    stop = 1'b1;
    @(negedge clk_25MHz);
    stop = 1'b0;
    checkOutput("s5_stop_valid", 32'(spawn_valid), 32'd0);
    checkOutput("s5_stop_queue_done", 32'(queue_done), 32'd0);
    checkOutput("s5_stop_game_time", 32'(game_time), 32'd5);
    pulseTick();
    checkOutput("s5_idle_game_time", 32'(game_time), 32'd5);
    level_sel = 2'd2;
    level_start = 1'b1;
    stop = 1'b1;
    @(negedge clk_25MHz);
    level_start = 1'b0;
    stop = 1'b0;
    checkOutput("s5_restart_game_time", 32'(game_time), 32'd0);
    checkOutput("s5_restart_q_addr", 32'(q_addr), 32'h100);
    pulseTick();
    checkOutput("s5_start_beats_stop", 32'(game_time), 32'd1);
    stop = 1'b1;
    @(negedge clk_25MHz);
    stop = 1'b0;

    $display("[TB] level 3: full queue without sentinel");
    base = xferCyc.size();
    for (int i = 0; i < 128; i++) begin
      rom[{2'd3, 7'(i)}] = {12'd0, 3'(i)};
      expectXfer(3'd0, 3'(i), {2'd3, 7'(i)});
    end
    engineEcho = 1'b1;
    spawn_ready = 1'b1;
    applyStimulus(2'd3);
    waitXfers(base + 128, 700, "s6_xfer_count");
    checkOutput("s6_queue_done", 32'(queue_done), 32'd1);
    checkOutput("s6_q_addr_last", 32'(q_addr), 32'h1FF);
    checkOutput("s6_scoreboard_drained", 32'(expQ.size()), 32'd0);
    cycles(5);
    engineEcho = 1'b0;
    spawn_ready = 1'b0;
    checkOutput("s6_q_addr_no_wrap", 32'(q_addr), 32'h1FF);
    checkOutput("s6_still_done", 32'(queue_done), 32'd1);

    $display("[TB] game_time in DONE and saturation");
    pulseTick();
    checkOutput("done_game_time_counts", 32'(game_time), 32'd1);
    frame_tick = 1'b1;
    cycles(4092);
    checkOutput("game_time_ffd", 32'(game_time), 32'hFFD);
    cycles(10);
    frame_tick = 1'b0;
    checkOutput("game_time_saturates", 32'(game_time), 32'hFFE);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/enemy_spawner.md
ENEMY_SPAWNER -- requirements
Module: enemy_spawner

Interface
REQ-001 The block SHALL have these parameters (name, default, meaning):
- QDEPTH, 128, queue entries per level
- NSLOT, 8, enemy instance slots
REQ-002 The block SHALL have these ports (name  direction  width  meaning):
- clk_25MHz  in  1  clock
- rst  in  1  reset; synchronous, active-high
- level_start  in  1  one-cycle pulse; start the level given by level_sel
- level_sel  in  2  1/2/3 = level; 0 = ignore
- stop  in  1  leave play scene (win/lose)
- pause  in  1  freeze game time
- frame_tick  in  1  one-cycle pulse per game frame
- q_addr  out  9  queue ROM address {level_sel[1:0], index[6:0]}
- q_data  in  15  ROM entry {timestamp[14:3], type[2:0]}; valid 1 cycle after q_addr
- enemy_exist  in  NSLOT  per-slot exist bits (Enemy_Instance[i][55])
- spawn_valid  out  1  spawn request offered
- spawn_ready  in  1  engine accepts request
- spawn_slot  out  3  target free slot
- spawn_type  out  3  enemy type
- game_time  out  12  frames since level start
- queue_done  out  1  queue exhausted

Function
REQ-003 The FSM SHALL have these states: IDLE, FETCH, WAIT, HOLD, ALLOC, OFFER, DONE.
REQ-004 In IDLE, on level_start with level_sel != 0: latch level_sel, index=0, game_time=0, reserved mask=0, go to FETCH. level_sel=0 SHALL be ignored.
REQ-005 FETCH SHALL drive q_addr and go to WAIT. WAIT SHALL register q_data into ts/type and go to HOLD.
REQ-006 In HOLD, a registered timestamp of 12'hFFF is the end sentinel and SHALL cause a transition to DONE.
REQ-007 In HOLD, a non-sentinel entry SHALL go to ALLOC in the first cycle in which game_time >= ts; an entry whose ts is already past SHALL spawn immediately.
REQ-008 ALLOC SHALL select the lowest index i with enemy_exist[i]=0 and reserved[i]=0, load spawn_slot/spawn_type, and go to OFFER in the next cycle.
REQ-009 With no free slot, the FSM SHALL stay in ALLOC and re-evaluate every cycle; game_time keeps running; no entry is dropped.
REQ-010 In OFFER, spawn_valid=1 and spawn_slot/spawn_type SHALL be held stable until spawn_valid && spawn_ready. On that transfer:
- set reserved[spawn_slot]
- index+1
- go to FETCH
REQ-011 Handshake: spawn_valid SHALL be deasserted only after a transfer, or by stop/rst/level_start.
REQ-012 reserved[i] SHALL clear in the cycle after enemy_exist[i] is observed 1.
REQ-013 Consecutive entries with equal timestamps SHALL spawn back-to-back, at most one transfer per 4 cycles (FETCH, WAIT, HOLD/ALLOC, OFFER).
REQ-014 After consuming index QDEPTH-1 without a sentinel, the FSM SHALL go to DONE; index SHALL never wrap.
REQ-015 queue_done SHALL equal (state==DONE). game_time SHALL keep counting in DONE.
REQ-016 game_time SHALL increment on frame_tick && !pause in any state except IDLE, and SHALL saturate at 12'hFFE (it never reaches the sentinel).
REQ-017 pause SHALL NOT block an in-progress OFFER transfer.
REQ-018 stop SHALL force IDLE in the next cycle from any state, clearing spawn_valid and queue_done; game_time holds its value.
REQ-019 level_start with a valid level_sel in any non-IDLE state SHALL restart per REQ-004; if it coincides with stop, level_start SHALL win.
REQ-020 If spawn_ready and level_start arrive in the same cycle, the transfer SHALL NOT count: reserved and index are reinitialised.

Reset
REQ-021 On rst the block SHALL set:
- state=IDLE
- spawn_valid=0, spawn_slot=0, spawn_type=0
- game_time=0, queue_done=0
- q_addr=0, reserved=0, index=0
rst SHALL take priority over all other inputs.

Structure
REQ-022 The shared game package SHALL hold the FSM state enum, the 12'hFFF sentinel constant, the queue entry field positions, and NSLOT.
REQ-023 The lowest-free-slot priority encoder (NSLOT-bit mask in, index + found out) SHALL be a sub-module, free_slot_finder.

Verification
REQ-024 The bench SHALL cover these directed scenarios:
- Level 2 start; ROM entries (ts=5,type=3), (ts=FFF) -> spawn_valid rises within 4 cycles after the 5th frame_tick; slot=0, type=3; queue_done=1 after the transfer.
- Entries (ts=10,t=1), (ts=10,t=2), (ts=10,t=4); spawn_ready tied high -> three transfers to slots 0,1,2, spaced 4 cycles apart.
- enemy_exist=8'hFF at ts -> spawn_valid stays 0; clearing bit 5 -> spawn_slot=5 one cycle later.
- Offer pending, spawn_ready=0 for 20 cycles -> slot/type stable, no index advance; pause held for 10 ticks -> game_time frozen.
- stop asserted during OFFER -> IDLE next cycle, spawn_valid=0; later level_start -> game_time=0, fetch from q_addr={lvl,0}.
- 128 entries with no sentinel -> DONE after the 128th transfer; q_addr never wraps to index 0.
